// File: rtl/rr_arb_pkg.sv
// Shared constants and helpers for the round-robin arbiter pipeline stage.
package rr_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 3;
    localparam int CNT_W_DEF   = 8;

    // Index width for a requester count; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    pick,
    output logic               any
);

    int idx;

    // Scan from the farthest offset down so the nearest valid requester wins last.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = 0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            idx = (int'(ptr) + j) % NUM_REQ;
            if (valid[idx]) begin
                pick = ID_W'(idx);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_pipe.sv
// Round-robin arbiter feeding one registered valid/ready stage.
// Optional per-requester grant counters with ARB_GRANT_CNT_EN.
module rr_arb_pipe
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ID_W    = id_width(NUM_REQ),
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        valid_up,
    input  logic [NUM_REQ*DATA_W-1:0] data_up,
    output logic [NUM_REQ-1:0]        ready_up,
    output logic                      valid_down,
    output logic [DATA_W-1:0]         data_down,
    output logic [ID_W-1:0]           grant_id,
    input  logic                      ready_down
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]  grant_cnt
`endif
);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   pick;
    logic [ID_W-1:0]   ptr_nxt;
    logic [DATA_W-1:0] sel_data;
    logic              any;
    logic              slot_free;
    logic              accept;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .valid (valid_up),
        .ptr   (ptr),
        .pick  (pick),
        .any   (any)
    );

    assign slot_free = ready_down | ~valid_down;
    assign accept    = slot_free & any;
    assign sel_data  = data_up[pick*DATA_W +: DATA_W];
    // Explicit wrap so non-power-of-2 NUM_REQ never lands on an unused index.
    assign ptr_nxt   = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + ID_W'(1);

    always_comb begin
        ready_up = '0;
        if (accept) ready_up[pick] = 1'b1;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_down <= 1'b0;
            data_down  <= '0;
            grant_id   <= '0;
            ptr        <= '0;
        end else if (slot_free) begin
            if (any) begin
                valid_down <= 1'b1;
                data_down  <= sel_data;
                grant_id   <= pick;
                ptr        <= ptr_nxt;
            end else begin
                valid_down <= 1'b0;
            end
        end
    end

`ifdef ARB_GRANT_CNT_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else if (accept && pick == ID_W'(i) && cnt != '1)
                cnt <= cnt + CNT_W'(1);
        end

        assign grant_cnt[i*CNT_W +: CNT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_rr_arb_pipe.sv
// Randomized scoreboard bench for rr_arb_pipe against a queue-based reference model.
module tb_rr_arb_pipe;
    import rr_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 3;
    localparam int IW = id_width(N);
    localparam int CW = 8;

    logic            sys_clk = 1'b0;
    logic            rst_n   = 1'b0;
    logic [N-1:0]    valid_up = '0;
    logic [N*DW-1:0] data_up  = '0;
    logic [N-1:0]    ready_up;
    logic            valid_down;
    logic [DW-1:0]   data_down;
    logic [IW-1:0]   grant_id;
    logic            ready_down = 1'b0;
`ifdef ARB_GRANT_CNT_EN
    logic [N*CW-1:0] grant_cnt;
`endif

    always #5 sys_clk = ~sys_clk;

    rr_arb_pipe #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .valid_up   (valid_up),
        .data_up    (data_up),
        .ready_up   (ready_up),
        .valid_down (valid_down),
        .data_down  (data_down),
        .grant_id   (grant_id),
        .ready_down (ready_down)
`ifdef ARB_GRANT_CNT_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] d;
    } beat_t;

    beat_t sb[$];
    int checks = 0;
    int errors = 0;

    // Upstream requester state and committed model state (valid after each posedge).
    bit            has[N];
    logic [DW-1:0] dat[N];
    bit            out_full = 1'b0;
    int            ptr      = 0;
    int            last_id  = 0;
    int            last_d   = 0;
    int            cnt[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int p_req, input int p_rd, input bit fixed, input bit [N-1:0] mask);
        bit sf;
        int pk;
        bit n_full;
        int n_ptr, n_id, n_d;
        logic [31:0] exp_rdy;
        @(negedge sys_clk);
        for (int i = 0; i < N; i++) begin
            if (!has[i] && mask[i] && $urandom_range(99) < p_req) begin
                has[i] = 1'b1;
                dat[i] = fixed ? DW'(i) : DW'($urandom);
            end
            valid_up[i] = has[i];
            data_up[i*DW +: DW] = dat[i];
        end
        ready_down = ($urandom_range(99) < p_rd);
        #1;
        sf = ready_down || !out_full;
        pk = -1;
        for (int o = 0; o < N; o++)
            if (pk < 0 && has[(ptr + o) % N]) pk = (ptr + o) % N;
        exp_rdy = (sf && pk >= 0) ? (32'd1 << pk) : 32'd0;
        chk("ready_up", 32'(ready_up), exp_rdy);
        n_full = out_full; n_ptr = ptr; n_id = last_id; n_d = last_d;
        if (sf) begin
            if (pk >= 0) begin
                sb.push_back('{id: IW'(pk), d: dat[pk]});
                n_full = 1'b1;
                n_ptr  = (pk + 1) % N;
                n_id   = pk;
                n_d    = int'(dat[pk]);
                has[pk] = 1'b0;
            end else begin
                n_full = 1'b0;
            end
        end
        @(posedge sys_clk);
        out_full = n_full; ptr = n_ptr; last_id = n_id; last_d = n_d;
        if (sf && pk >= 0 && cnt[pk] < (1 << CW) - 1) cnt[pk]++;
    endtask

    task automatic mid_reset();
        @(negedge sys_clk);
        #1;
        chk("valid_down_before_reset", 32'(valid_down), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_valid_down", 32'(valid_down), 32'd0);
        chk("rst_data_down", 32'(data_down), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        sb.delete();
        out_full = 1'b0; ptr = 0; last_id = 0; last_d = 0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        @(posedge sys_clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: output stage must match model occupancy; beats leave in scoreboard order.
    initial begin
        beat_t b;
        forever begin
            @(negedge sys_clk);
            #2;
            if (rst_n) begin
                chk("valid_down", 32'(valid_down), 32'(out_full));
                if (valid_down) begin
                    if (sb.size() == 0) begin
                        chk("sb_nonempty", 32'd0, 32'd1);
                    end else begin
                        b = sb[0];
                        chk("grant_id", 32'(grant_id), 32'(b.id));
                        chk("data_down", 32'(data_down), 32'(b.d));
                        if (ready_down) void'(sb.pop_front());
                    end
                end else begin
                    chk("idle_grant_id_hold", 32'(grant_id), 32'(last_id));
                    chk("idle_data_hold", 32'(data_down), 32'(last_d));
                end
`ifdef ARB_GRANT_CNT_EN
                for (int i = 0; i < N; i++)
                    chk("grant_cnt", 32'(grant_cnt[i*CW +: CW]), 32'(cnt[i]));
`endif
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin has[i] = 1'b0; dat[i] = '0; cnt[i] = 0; end
        #12;
        chk("reset_valid_down", 32'(valid_down), 32'd0);
        chk("reset_data_down", 32'(data_down), 32'd0);
        chk("reset_grant_id", 32'(grant_id), 32'd0);
        @(posedge sys_clk);
        #1 rst_n = 1'b1;

        repeat (12) step(100, 100, 1'b1, 4'b1111);   // full streaming, rotation 0..3
        mid_reset();
        repeat (8)   step(100, 100, 1'b1, 4'b1111);
        repeat (6)   step(0, 100, 1'b0, 4'b1111);    // drain
        repeat (8)   step(100, 100, 1'b0, 4'b0100);  // lone requester 2
        repeat (4)   step(0, 100, 1'b0, 4'b1111);
        repeat (40)  step(80, 40, 1'b0, 4'b1010);    // requesters 1 and 3 with stalls
        repeat (600) step(40, 60, 1'b0, 4'b1111);
        repeat (200) step(70, 20, 1'b0, 4'b1111);    // heavy backpressure
        repeat (10)  step(0, 100, 1'b0, 4'b1111);
        repeat (300) step(100, 100, 1'b0, 4'b0001);  // saturates requester 0's counter
        repeat (10)  step(0, 100, 1'b0, 4'b1111);

        @(negedge sys_clk);
        #3;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
